redundancy_expander: RTL and testbench
======================================

// Module: redundancy_expander
// PURPOSE
//  Inverse of the redundancy controller's compression path. Takes one dense column plus its
//  mapping-table (MT) column and rebuilds the full STEP_RANGE-wide column.
//  Sits after the PE array / dense LIFM consumer and restores original column positions:
//  out[i] = dense[j] where MT row i is one-hot at j.
//  Expands LANES positions per cycle to bound mux cost. Column-level valid/ready on both sides.
// PARAMETERS
//  WORD_WIDTH   8    bits per element
//  STEP_RANGE   128  column height / MT row count and row width; must be a multiple of LANES
//  LANES        8    output positions resolved per EXPAND cycle
// PORTS
//  clk           in   1                        rising-edge clock
//  reset         in   1                        synchronous, active-high reset
//  in_valid      in   1                        dense column + MT column present
//  in_ready      out  1                        block can accept a column this cycle
//  dense_column  in   WORD_WIDTH*STEP_RANGE    dense values; element j = bits [j*WW +: WW]
//  mt_column     in   STEP_RANGE*STEP_RANGE    MT; row i = bits [i*SR +: SR], bit j selects dense j
//  out_valid     out  1                        out_column holds a complete expanded column
//  out_ready     in   1                        downstream accepts out_column
//  out_column    out  WORD_WIDTH*STEP_RANGE    expanded column; element i = bits [i*WW +: WW]
//  mt_error      out  1                        current output column had >=1 multi-hot MT row
// BEHAVIOUR
//  Reset: state=IDLE; pos_cnt=0; out_valid=0; out_column=0; mt_error=0; buffers cleared.
//    Reset wins over every other event. A column in flight is discarded; no partial output.
//  FSM states: IDLE, EXPAND, OUT.
//   IDLE:   in_ready=1. in_valid&&in_ready -> latch both inputs into buffers,
//           clear out_column/mt_error, pos_cnt=0, go to EXPAND.
//   EXPAND: each cycle resolves positions p = pos_cnt*LANES + k, k=0..LANES-1, into out_column.
//           pos_cnt wraps at STEP_RANGE/LANES-1 -> OUT, out_valid=1 on entry.
//           in_ready=0.
//   OUT:    out_valid=1. out_column and mt_error held stable while out_ready=0.
//           out_ready=1 -> out_valid=0 next cycle.
//           Simultaneous in_valid: in_ready = out_ready in this state. Back-to-back accept goes
//           straight to EXPAND with no IDLE bubble.
//  Latency: accept at edge t -> out_valid at edge t + STEP_RANGE/LANES. Throughput: one column
//    per STEP_RANGE/LANES+1 cycles with out_ready held high.
//  Per-position rule (row r of MT):
//    zero row    -> element = 0 (position pruned), no error.
//    one-hot at j -> element = dense[j].
//    multi-hot   -> element = dense[lowest set j]; mt_error set (sticky for this column).
//  No arithmetic on data. Elements are copied bit-exact. pos_cnt width = clog2(STEP_RANGE/LANES), min 1.
//  Inputs are sampled only on the accept edge; later changes to dense/mt inputs have no effect.
//  out_ready outside OUT is ignored.
// STRUCTURE
//  Shared package/header redundancy_defs: WORD_WIDTH, STEP_RANGE defaults; state encoding
//    (IDLE=0, EXPAND=1, OUT=2); element/MT-row slice macros, shared with the controller.
//  Sub-module onehot_word_select: SR-bit row + dense bus -> WW-bit word + multi_hot flag.
//    Combinational, lowest-index priority. Instantiated LANES times, fed from the row selected by pos_cnt.
// TESTING  (SR=8, LANES=2, WW=8 unless noted)
//  1 Identity MT (row i = 1<<i), dense[i]=i+1, out_ready=1 -> out_column = {8,7,...,1}.
//    out_valid exactly 4 cycles after accept; mt_error=0.
//  2 All rows = 8'b0000_0001, dense[0]=8'hA5 -> every element 8'hA5 (broadcast of one dense word).
//  3 Rows 3 and 6 = 0, others identity -> elements 3,6 = 0. Remaining elements = dense[i].
//  4 Row 2 = 8'b0001_0100 -> element 2 = dense[2]; mt_error=1.
//    Next column with a clean MT -> mt_error=0.
//  5 Hold out_ready=0 for 10 cycles in OUT while driving new in_valid -> out_column stable, in_ready=0.
//    Raise out_ready -> new column accepted same edge; next out_valid 4 cycles later.
//  6 Assert reset during EXPAND (pos_cnt=2) -> next cycle IDLE, out_valid=0, out_column=0, in_ready=1.
//    No output ever produced for the aborted column.

Source files
------------

// File: rtl/redundancy_defs.sv
// Shared definitions for the redundancy controller / expander pair: default
// geometry and the expander FSM encoding.
package redundancy_defs;

  localparam int WORD_WIDTH_DEF = 8;
  localparam int STEP_RANGE_DEF = 128;
  localparam int LANES_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_word_select.sv
// Picks the dense word addressed by one MT row; lowest set bit wins and
// more than one set bit raises multi_hot.
module onehot_word_select
  import redundancy_defs::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int STEP_RANGE = STEP_RANGE_DEF
) (
  input  logic [STEP_RANGE-1:0]            row,
  input  logic [WORD_WIDTH*STEP_RANGE-1:0] dense,
  output logic [WORD_WIDTH-1:0]            word,
  output logic                             multi_hot
);

  // Scan downward so the lowest set index is the final assignment.
  always_comb begin
    word = '0;
    for (int j = STEP_RANGE - 1; j >= 0; j--) begin
      if (row[j]) word = dense[j*WORD_WIDTH +: WORD_WIDTH];
    end
    multi_hot = ($countones(row) > 1);
  end

endmodule

// File: rtl/redundancy_expander.sv
// Rebuilds a full column from a dense column and its mapping table,
// resolving LANES output positions per cycle.
module redundancy_expander
  import redundancy_defs::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int STEP_RANGE = STEP_RANGE_DEF,
  parameter int LANES      = LANES_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_WIDTH*STEP_RANGE-1:0] dense_column,
  input  logic [STEP_RANGE*STEP_RANGE-1:0] mt_column,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_WIDTH*STEP_RANGE-1:0] out_column,
  output logic                             mt_error
);

  localparam int NPOS = STEP_RANGE / LANES;
  localparam int PW   = (NPOS > 1) ? $clog2(NPOS) : 1;
  localparam int RIW  = $clog2(STEP_RANGE * STEP_RANGE);
  localparam int EIW  = $clog2(WORD_WIDTH * STEP_RANGE);
  localparam logic [PW-1:0] POS_LAST = PW'(NPOS - 1);

  state_t                           state, state_nxt;
  logic [PW-1:0]                    pos_cnt;
  logic [WORD_WIDTH*STEP_RANGE-1:0] dense_buf;
  logic [STEP_RANGE*STEP_RANGE-1:0] mt_buf;
  logic [WORD_WIDTH*STEP_RANGE-1:0] out_col_q;
  logic                             mt_err_q;
  logic [WORD_WIDTH-1:0]            lane_word [LANES];
  logic [LANES-1:0]                 lane_multi;
  logic                             accept;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_EXPAND;
      end
      ST_EXPAND: begin
        if (pos_cnt == POS_LAST) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? ST_EXPAND : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [RIW-1:0]        row_base;
    logic [STEP_RANGE-1:0] row;

    always_comb begin
      row_base = RIW'((int'(pos_cnt) * LANES + k) * STEP_RANGE);
      row      = mt_buf[row_base +: STEP_RANGE];
    end

    onehot_word_select #(
      .WORD_WIDTH (WORD_WIDTH),
      .STEP_RANGE (STEP_RANGE)
    ) u_sel (
      .row       (row),
      .dense     (dense_buf),
      .word      (lane_word[k]),
      .multi_hot (lane_multi[k])
    );
  end

  // Accept stage latches the column; EXPAND stage fills LANES slots per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pos_cnt   <= '0;
      dense_buf <= '0;
      mt_buf    <= '0;
      out_col_q <= '0;
      mt_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dense_buf <= dense_column;
        mt_buf    <= mt_column;
        out_col_q <= '0;
        mt_err_q  <= 1'b0;
        pos_cnt   <= '0;
      end else if (state == ST_EXPAND) begin
        for (int k = 0; k < LANES; k++) begin
          out_col_q[EIW'((int'(pos_cnt) * LANES + k) * WORD_WIDTH) +: WORD_WIDTH] <= lane_word[k];
        end
        if (|lane_multi) mt_err_q <= 1'b1;
        pos_cnt <= (pos_cnt == POS_LAST) ? '0 : pos_cnt + 1'b1;
      end
    end
  end

  assign out_column = out_col_q;
  assign mt_error   = mt_err_q;

endmodule

// File: tb/tb_redundancy_expander.sv
// Directed bench for redundancy_expander at SR=8, LANES=2, WW=8.
module tb_redundancy_expander;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dense_column;
  logic [63:0] mt_column;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_column;
  logic        mt_error;

  int checks = 0;
  int errors = 0;
  int lat;
  int seen;

  localparam logic [63:0] MT_ID    = 64'h8040_2010_0804_0201;
  localparam logic [63:0] DENSE_UP = 64'h0807_0605_0403_0201;

  always #5 clk = ~clk;

  redundancy_expander #(
    .WORD_WIDTH (8),
    .STEP_RANGE (8),
    .LANES      (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dense_column (dense_column),
    .mt_column    (mt_column),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_column   (out_column),
    .mt_error     (mt_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [63:0] m);
    int n;
    n = 0;
    in_valid     = 1'b1;
    dense_column = d;
    mt_column    = m;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid     = 1'b0;
    dense_column = '1;
    mt_column    = '1;
  endtask

  task automatic wait_out(output int l);
    l = 0;
    while (!out_valid && l < 20) begin
      @(posedge clk); #1; l++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("pop_valid_low", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    dense_column = '0;
    mt_column    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_column", out_column, 64'd0);
    chk("rst_mt_error",  {63'd0, mt_error},  64'd0);

    // Identity mapping
    send(DENSE_UP, MT_ID);
    wait_out(lat);
    chk("id_latency", 64'(lat), 64'd4);
    chk("id_column", out_column, 64'h0807_0605_0403_0201);
    chk("id_err", {63'd0, mt_error}, 64'd0);
    pop();

    // Broadcast of dense[0]
    send(64'h1122_3344_5566_77A5, 64'h0101_0101_0101_0101);
    wait_out(lat);
    chk("bc_latency", 64'(lat), 64'd4);
    chk("bc_column", out_column, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("bc_err", {63'd0, mt_error}, 64'd0);
    pop();

    // Pruned rows 3 and 6
    send(DENSE_UP, 64'h8000_2010_0004_0201);
    wait_out(lat);
    chk("prune_column", out_column, 64'h0800_0605_0003_0201);
    chk("prune_err", {63'd0, mt_error}, 64'd0);
    pop();

    // Multi-hot row 2 -> lowest index (dense[2]=0x12, not dense[4]=0x14)
    send(64'h1716_1514_1312_1110, 64'h8040_2010_0814_0201);
    wait_out(lat);
    chk("mh_column", out_column, 64'h1716_1514_1312_1110);
    chk("mh_err", {63'd0, mt_error}, 64'd1);
    pop();
    send(64'h1716_1514_1312_1110, MT_ID);
    wait_out(lat);
    chk("clean_err", {63'd0, mt_error}, 64'd0);
    chk("clean_column", out_column, 64'h1716_1514_1312_1110);
    pop();

    // Backpressure in OUT with a pending column
    send(DENSE_UP, 64'h0102_0408_1020_4080);
    wait_out(lat);
    in_valid     = 1'b1;
    dense_column = 64'hF0E0_D0C0_B0A0_9080;
    mt_column    = MT_ID;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_column", out_column, 64'h0102_0304_0506_0708);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    out_ready    = 1'b0;
    in_valid     = 1'b0;
    dense_column = '1;
    mt_column    = '1;
    chk("b2b_valid_low", {63'd0, out_valid}, 64'd0);
    chk("b2b_in_ready", {63'd0, in_ready}, 64'd0);
    wait_out(lat);
    chk("b2b_latency", 64'(lat), 64'd4);
    chk("b2b_column", out_column, 64'hF0E0_D0C0_B0A0_9080);
    pop();

    // Reset in the middle of EXPAND (pos_cnt == 2)
    send(DENSE_UP, MT_ID);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_column", out_column, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_err", {63'd0, mt_error}, 64'd0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_output", 64'(seen), 64'd0);

    // Normal operation resumes after the abort
    send(64'h1716_1514_1312_1110, 64'h0102_0408_1020_4080);
    wait_out(lat);
    chk("resume_latency", 64'(lat), 64'd4);
    chk("resume_column", out_column, 64'h1011_1213_1415_1617);
    pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
